systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencer for the SIZE x SIZE output-stationary systolic multiplier array.
- Holds operand matrices A and B in local buffers that are loaded row by row.
- On start, clears the array accumulators, then drives skewed A rows and B columns into the array edges.
- Waits for the array to drain, captures the full C result, and presents it with a valid/ready handshake.
- Sits between the host/bus side and the array instance.

Parameters:
SIZE, 3, matrix dimension N (N >= 2)
DATA_WIDTH, 10, operand element width; result elements are 2*DATA_WIDTH, unsigned

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
load_en  in  1  write one operand row this cycle
load_sel  in  1  0 = A buffer, 1 = B buffer
load_row  in  $clog2(SIZE)  row index to write
load_data  in  SIZE*DATA_WIDTH  row elements; element k at [k*DATA_WIDTH +: DATA_WIDTH]
start  in  1  begin a multiply (single-cycle pulse or level)
busy  out  1  high from start acceptance until result handshake completes
array_rst_n  out  1  active-low clear to array PEs
a_feed  out  SIZE*DATA_WIDTH  west-edge inputs; lane i drives array row i
b_feed  out  SIZE*DATA_WIDTH  north-edge inputs; lane j drives array column j
c_in  in  SIZE*SIZE*2*DATA_WIDTH  array accumulators; C[i][j] at [(i*SIZE+j)*2*DATA_WIDTH +: 2*DATA_WIDTH]
result  out  SIZE*SIZE*2*DATA_WIDTH  captured C, same packing as c_in
result_valid  out  1  result holds a completed product
result_ready  in  1  consumer accepts result

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; A and B buffers are cleared to 0.
  - busy=0, array_rst_n=0, a_feed=0, b_feed=0, result=0, result_valid=0.
- All outputs are registered.
- FSM states: IDLE -> CLEAR -> FEED -> DRAIN -> CAPTURE -> HOLD -> IDLE.
- IDLE:
  - load_en writes load_data into buffer[load_sel] row load_row on the clock edge.
  - start=1 moves to CLEAR and sets busy=1 the next cycle.
  - If load_en and start occur in the same cycle, the write completes first and the multiply uses the new row.
- CLEAR: 1 cycle with array_rst_n=0 and feeds=0. array_rst_n is 1 in every other state, including IDLE after the first start.
- FEED: 3*SIZE-2 cycles; counter t runs 0..3*SIZE-3.
  - a_feed lane i = A[i][t-i] when 0 <= t-i < SIZE, else 0.
  - b_feed lane j = B[t-j][j] when 0 <= t-j < SIZE, else 0.
  - Feed values are registered, so they appear one cycle after the state/counter that selects them.
- DRAIN: 2 cycles with feeds=0. This lets the final product reach PE(SIZE-1,SIZE-1).
- CAPTURE: 1 cycle; result <= c_in. result_valid=1 from the next cycle.
- HOLD:
  - result_valid=1 and result stays stable until result_ready=1 is seen with result_valid=1.
  - After that: result_valid=0, busy=0, state IDLE on the same edge.
  - result keeps its last value after the handshake.
- Total latency from accepted start to first result_valid: 1 + (3*SIZE-2) + 2 + 1 + 1 = 3*SIZE+3 cycles (12 for SIZE=3).
- Boundary rules:
  - start outside IDLE is ignored.
  - load_en while busy=1 is ignored; buffers are unchanged.
  - load_row >= SIZE is ignored (non-power-of-2 SIZE).
  - Arithmetic is unsigned and wraps modulo 2^(2*DATA_WIDTH), as accumulated by the array; the controller does no arithmetic on C.
  - rst mid-operation aborts at once to reset values; a new run requires reloading A and B.
- FEED counter width is $clog2(3*SIZE); it is cleared on entry to FEED and DRAIN.

Decomposition:
- Shared package:
  - state encoding enum (IDLE, CLEAR, FEED, DRAIN, CAPTURE, HOLD)
  - localparams FEED_CYCLES = 3*SIZE-2, DRAIN_CYCLES = 2, CW = 2*DATA_WIDTH
- One natural sub-module, systolic_skew_mux: combinational selection of a_feed/b_feed lanes from the buffers and t. Registration stays in the top.

Test Plan:
- A = identity, B = [[1,2,3],[4,5,6],[7,8,9]], start -> result_valid at cycle 12 after start; result = B.
- A all 1, B all 2 -> every C element = 6. Check a_feed lane 2 is 0 for t < 2, then 1, 1, 1, then 0.
- A and B all 1023 -> each C = 3*1023^2 mod 2^20 = 1042435 (wrap check).
- result_ready held 0 for 10 cycles in HOLD, with start and load_en pulsed -> result stable, result_valid=1, busy=1, buffers unchanged. On ready=1, one handshake, then busy=0.
- rst=1 during FEED at t=3 -> next cycle all outputs at reset values. Reload, restart -> correct product, no residue from the aborted run.
- Back-to-back runs with different B -> second result correct. array_rst_n=0 for exactly 1 cycle per run.

Source files
------------

// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the systolic array sequencer.
// Sizes that depend on SIZE/DATA_WIDTH are provided as functions so every file derives them the same way.
package systolic_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  localparam int DEF_SIZE       = 3;
  localparam int DEF_DATA_WIDTH = 10;
  localparam int DRAIN_CYCLES   = 2;

  function automatic int feed_cycles(input int n);
    return 3*n - 2;
  endfunction

  function automatic int res_width(input int dw);
    return 2*dw;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host/array-facing bus of the sequencer: operand loading, start/busy,
// skewed edge feeds, accumulator readback and the result handshake.
interface systolic_seq_ctrl_if
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int SIZE       = DEF_SIZE,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  localparam int RW    = $clog2(SIZE);
  localparam int RES_W = res_width(DATA_WIDTH);

  logic                           load_en;
  logic                           load_sel;
  logic [RW-1:0]                  load_row;
  logic [SIZE*DATA_WIDTH-1:0]     load_data;
  logic                           start;
  logic                           busy;
  logic                           array_rst_n;
  logic [SIZE*DATA_WIDTH-1:0]     a_feed;
  logic [SIZE*DATA_WIDTH-1:0]     b_feed;
  logic [SIZE*SIZE*RES_W-1:0]     c_in;
  logic [SIZE*SIZE*RES_W-1:0]     result;
  logic                           result_valid;
  logic                           result_ready;

  modport master (
    output load_en, load_sel, load_row, load_data, start, result_ready, c_in,
    input  busy, array_rst_n, a_feed, b_feed, result, result_valid
  );

  modport slave (
    input  load_en, load_sel, load_row, load_data, start, result_ready, c_in,
    output busy, array_rst_n, a_feed, b_feed, result, result_valid
  );

endinterface

// File: rtl/systolic_skew_mux.sv
// Picks the diagonal slice of A and B for feed step t: lane i carries
// A[i][t-i] on the west edge and B[t-i][i] on the north edge, zero outside the band.
module systolic_skew_mux #(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 10,
  parameter int CNT_W      = 4
) (
  input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] i_a,
  input  logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] i_b,
  input  logic [CNT_W-1:0]                          i_t,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]           o_a,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]           o_b
);

  always_comb begin
    o_a = '0;
    o_b = '0;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < SIZE; k++) begin
        if (int'(i_t) == i + k) begin
          o_a[i] = i_a[i][k];
          o_b[i] = i_b[k][i];
        end
      end
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for a SIZE x SIZE output-stationary systolic multiplier: buffers A/B,
// clears the array, streams skewed operands, waits out the pipeline and hands C to the host.
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int SIZE       = 3,
  parameter int DATA_WIDTH = 10
) (
  input  logic               clk,
  input  logic               rst,
  systolic_seq_ctrl_if.slave bus
);

  localparam int RES_W  = res_width(DATA_WIDTH);
  localparam int FEED_N = feed_cycles(SIZE);
  localparam int CNT_W  = $clog2(3*SIZE);

  typedef logic [SIZE-1:0][SIZE-1:0][DATA_WIDTH-1:0] mat_t;
  typedef logic [SIZE-1:0][DATA_WIDTH-1:0]           row_t;

  state_t                     r_state, w_next;
  logic [CNT_W-1:0]           r_t;
  mat_t                       r_a, r_b;
  row_t                       w_a_lane, w_b_lane;
  row_t                       r_a_feed, r_b_feed;
  logic [SIZE*SIZE*RES_W-1:0] r_result;
  logic                       r_busy, r_arst_n, r_valid;
  logic                       w_busy_d, w_arst_n_d, w_valid_d, w_cap;
  logic                       w_load, w_hs;

  // Buffers are only writable while idle; a same-cycle start still sees the new row.
  assign w_load = bus.load_en && (r_state == ST_IDLE) && (int'(bus.load_row) < SIZE);
  assign w_hs   = (r_state == ST_HOLD) && r_valid && bus.result_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_busy_d   = 1'b0;
    w_arst_n_d = 1'b1;
    w_valid_d  = 1'b0;
    w_cap      = 1'b0;
    unique case (r_state)
      ST_IDLE:    if (bus.start) w_next = ST_CLEAR;
      ST_CLEAR:   w_next = ST_FEED;
      ST_FEED:    if (r_t == CNT_W'(FEED_N - 1)) w_next = ST_DRAIN;
      ST_DRAIN:   if (r_t == CNT_W'(DRAIN_CYCLES - 1)) w_next = ST_CAPTURE;
      ST_CAPTURE: begin
        w_next = ST_HOLD;
        w_cap  = 1'b1;
      end
      ST_HOLD:    if (w_hs) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    w_busy_d  = (w_next != ST_IDLE);
    w_valid_d = (w_next == ST_HOLD);
    if (w_next == ST_CLEAR)      w_arst_n_d = 1'b0;
    else if (r_state == ST_IDLE) w_arst_n_d = r_arst_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          r_t <= '0;
    else if (w_next != r_state)                       r_t <= '0;
    else if (r_state == ST_FEED || r_state == ST_DRAIN) r_t <= r_t + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0;
      r_b <= '0;
    end else if (w_load) begin
      if (bus.load_sel) r_b[bus.load_row] <= bus.load_data;
      else              r_a[bus.load_row] <= bus.load_data;
    end
  end

  systolic_skew_mux #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH),
    .CNT_W      (CNT_W)
  ) u_skew (
    .i_a (r_a),
    .i_b (r_b),
    .i_t (r_t),
    .o_a (w_a_lane),
    .o_b (w_b_lane)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_arst_n <= 1'b0;
      r_valid  <= 1'b0;
      r_a_feed <= '0;
      r_b_feed <= '0;
      r_result <= '0;
    end else begin
      r_busy   <= w_busy_d;
      r_arst_n <= w_arst_n_d;
      r_valid  <= w_valid_d;
      r_a_feed <= (r_state == ST_FEED) ? w_a_lane : '0;
      r_b_feed <= (r_state == ST_FEED) ? w_b_lane : '0;
      if (w_cap) r_result <= bus.c_in;
    end
  end

  assign bus.busy         = r_busy;
  assign bus.array_rst_n  = r_arst_n;
  assign bus.a_feed       = r_a_feed;
  assign bus.b_feed       = r_b_feed;
  assign bus.result       = r_result;
  assign bus.result_valid = r_valid;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Bench for systolic_seq_ctrl: a behavioural PE grid stands in for the array,
// and every feed, flag and result is compared against matrices the bench keeps itself.
module tb_systolic_seq_ctrl;

  localparam int N   = 3;
  localparam int DW  = 10;
  localparam int CW  = 2*DW;
  localparam int LAT = 3*N + 3;

  typedef logic [255:0] v_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  int ma [N][N], mb [N][N];
  int na [N][N], nb [N][N];

  systolic_seq_ctrl_if #(.SIZE(N), .DATA_WIDTH(DW)) bus ();

  systolic_seq_ctrl #(.SIZE(N), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output-stationary PE grid: A flows east, B flows south, each PE accumulates a*b.
  logic [DW-1:0] pa  [N][N];
  logic [DW-1:0] pb  [N][N];
  logic [CW-1:0] acc [N][N];
  logic [DW-1:0] m_ain, m_bin;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) m_ain = bus.a_feed[i*DW +: DW];
        else        m_ain = pa[i][j-1];
        if (i == 0) m_bin = bus.b_feed[j*DW +: DW];
        else        m_bin = pb[i-1][j];
        if (!bus.array_rst_n) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          pa[i][j]  <= m_ain;
          pb[i][j]  <= m_bin;
          acc[i][j] <= acc[i][j] + CW'(m_ain) * CW'(m_bin);
        end
      end
    end
  end

  always_comb begin
    bus.c_in = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        bus.c_in[(i*N+j)*CW +: CW] = acc[i][j];
  end

  task automatic chk(input string tag, input v_t got, input v_t exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [N*N*CW-1:0] ref_product();
    logic [N*N*CW-1:0] r;
    longint s;
    r = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        s = 0;
        for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
        r[(i*N+j)*CW +: CW] = CW'(s);
      end
    return r;
  endfunction

  function automatic logic [N*DW-1:0] ref_feed(input bit is_b, input int t);
    logic [N*DW-1:0] f;
    f = '0;
    for (int l = 0; l < N; l++)
      if (t - l >= 0 && t - l < N)
        f[l*DW +: DW] = DW'(is_b ? mb[t-l][l] : ma[l][t-l]);
    return f;
  endfunction

  task automatic wr_row(input bit sel, input int row, input logic [N*DW-1:0] data);
    bus.load_en   = 1'b1;
    bus.load_sel  = sel;
    bus.load_row  = row[1:0];
    bus.load_data = data;
    @(negedge clk);
    bus.load_en = 1'b0;
    if (row < N)
      for (int k = 0; k < N; k++) begin
        if (sel) mb[row][k] = int'(data[k*DW +: DW]);
        else     ma[row][k] = int'(data[k*DW +: DW]);
      end
  endtask

  task automatic load_all();
    logic [N*DW-1:0] ra, rb;
    for (int r = 0; r < N; r++) begin
      for (int k = 0; k < N; k++) begin
        ra[k*DW +: DW] = DW'(na[r][k]);
        rb[k*DW +: DW] = DW'(nb[r][k]);
      end
      wr_row(1'b0, r, ra);
      wr_row(1'b1, r, rb);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},   v_t'(bus.busy),         '0);
    chk({tag, "_arst_n"}, v_t'(bus.array_rst_n),  '0);
    chk({tag, "_a_feed"}, v_t'(bus.a_feed),       '0);
    chk({tag, "_b_feed"}, v_t'(bus.b_feed),       '0);
    chk({tag, "_result"}, v_t'(bus.result),       '0);
    chk({tag, "_valid"},  v_t'(bus.result_valid), '0);
  endtask

  // One multiply: start, per-cycle flag/feed checks, latency, result, optional stall, handshake.
  task automatic run(input int hold_cycles, input bit poke);
    int n;
    logic [N*N*CW-1:0] exp_res;
    exp_res = ref_product();
    chk("idle_busy", v_t'(bus.busy), '0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    n = 1;
    while (!bus.result_valid && n <= LAT + 4) begin
      chk("arst_n", v_t'(bus.array_rst_n), v_t'((n == 1) ? 1'b0 : 1'b1));
      chk("busy",   v_t'(bus.busy), v_t'(1'b1));
      chk("a_feed", v_t'(bus.a_feed), v_t'(ref_feed(1'b0, n - 3)));
      chk("b_feed", v_t'(bus.b_feed), v_t'(ref_feed(1'b1, n - 3)));
      if (poke && n == 4) begin
        bus.load_en   = 1'b1;
        bus.load_sel  = 1'b0;
        bus.load_row  = 2'd0;
        bus.load_data = '1;
        bus.start     = 1'b1;
      end else begin
        bus.load_en = 1'b0;
        bus.start   = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    bus.load_en = 1'b0;
    bus.start   = 1'b0;
    chk("latency", v_t'(n), v_t'(LAT));
    chk("result",  v_t'(bus.result), v_t'(exp_res));
    for (int d = 0; d < hold_cycles; d++) begin
      bus.result_ready = 1'b0;
      if (poke) begin
        bus.start     = d[0];
        bus.load_en   = ~d[0];
        bus.load_sel  = 1'b1;
        bus.load_row  = 2'd1;
        bus.load_data = (N*DW)'($urandom);
      end
      @(negedge clk);
      chk("hold_valid",  v_t'(bus.result_valid), v_t'(1'b1));
      chk("hold_busy",   v_t'(bus.busy), v_t'(1'b1));
      chk("hold_arst_n", v_t'(bus.array_rst_n), v_t'(1'b1));
      chk("hold_result", v_t'(bus.result), v_t'(exp_res));
    end
    bus.start        = 1'b0;
    bus.load_en      = 1'b0;
    bus.result_ready = 1'b1;
    @(negedge clk);
    bus.result_ready = 1'b0;
    chk("hs_valid",  v_t'(bus.result_valid), '0);
    chk("hs_busy",   v_t'(bus.busy), '0);
    chk("hs_result", v_t'(bus.result), v_t'(exp_res));
  endtask

  task automatic rand_mats(input bit only_b);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        if (!only_b) na[i][j] = $urandom_range(0, (1 << DW) - 1);
        nb[i][j] = $urandom_range(0, (1 << DW) - 1);
      end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.load_en      = 1'b0;
    bus.load_sel     = 1'b0;
    bus.load_row     = '0;
    bus.load_data    = '0;
    bus.start        = 1'b0;
    bus.result_ready = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("por");
    rst = 1'b0;

    // Identity times 1..9 returns B.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        na[i][j] = (i == j) ? 1 : 0;
        nb[i][j] = i*N + j + 1;
      end
    load_all();
    run(1, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk("ident_elem", v_t'(bus.result[(i*N+j)*CW +: CW]), v_t'(i*N + j + 1));

    // All-ones times all-twos; the out-of-range row write must be dropped.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        na[i][j] = 1;
        nb[i][j] = 2;
      end
    load_all();
    wr_row(1'b0, 3, '1);
    run(0, 1'b0);
    chk("ones_c00", v_t'(bus.result[0 +: CW]), v_t'(6));
    chk("ones_c22", v_t'(bus.result[(N*N-1)*CW +: CW]), v_t'(6));

    // Full-scale operands wrap modulo 2^20.
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        na[i][j] = 1023;
        nb[i][j] = 1023;
      end
    load_all();
    run(0, 1'b0);
    chk("wrap_c11", v_t'(bus.result[(N+1)*CW +: CW]), v_t'(1042435));

    // Stall in HOLD with start/load pokes, then rerun without reload: buffers must be intact.
    rand_mats(1'b0);
    load_all();
    run(10, 1'b1);
    run(0, 1'b0);

    // Abort in FEED at t=3; buffers clear, so an un-reloaded run yields zero.
    rand_mats(1'b0);
    load_all();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_busy", v_t'(bus.busy), v_t'(1'b1));
    rst = 1'b1;
    @(negedge clk);
    chk_reset("abort");
    rst = 1'b0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = 0;
        mb[i][j] = 0;
      end
    run(0, 1'b0);
    rand_mats(1'b0);
    load_all();
    run(2, 1'b0);

    // Randomized runs, alternating between new A/B and new B only.
    for (int it = 0; it < 6; it++) begin
      rand_mats(it[0]);
      load_all();
      run($urandom_range(0, 3), it[1]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
